// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin arbiter driving the shared 8:1 mux select
// Owner is released on done, on dropping its request, or after MAX_HOLD cycles when others wait.
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [7:0]       req,
  input  logic             done,
  output logic [7:0]       grant,
  output logic [2:0]       sel,
  output logic             grant_valid,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [7:0]       grant_q, grant_d;
  logic [2:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [2:0]       ptr_q, ptr_d;

  logic [7:0] owner_oh;
  logic [7:0] others;
  logic [2:0] next_ptr;
  logic [2:0] idle_pick;
  logic [2:0] rel_pick;
  logic       at_max;
  logic       release_owner;

  // First set bit of v at or after start, wrapping past 7; scanning downward keeps the closest.
  function automatic logic [2:0] rr_pick(input logic [7:0] v, input logic [2:0] start);
    logic [2:0] pick;
    logic [2:0] idx;
    pick = start;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (v[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign owner_oh      = 8'b1 << sel_q;
  assign others        = req & ~owner_oh;
  assign next_ptr      = sel_q + 3'd1;
  assign at_max        = (hold_q == HOLD_MAX);
  assign release_owner = done || !req[sel_q] || (at_max && (others != 8'h00));
  assign idle_pick     = rr_pick(req, ptr_q);
  assign rel_pick      = rr_pick(others, next_ptr);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= 8'h00;
      sel_q   <= 3'd0;
      valid_q <= 1'b0;
      hold_q  <= '0;
      ptr_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req != 8'h00) state_d = GRANT;
      GRANT:   if (release_owner && (others == 8'h00)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (req != 8'h00) begin
          grant_d = 8'b1 << idle_pick;
          sel_d   = idle_pick;
          valid_d = 1'b1;
          hold_d  = HOLD_ONE;
        end
      end
      GRANT: begin
        if (release_owner) begin
          ptr_d = next_ptr;
          if (others != 8'h00) begin
            grant_d = 8'b1 << rel_pick;
            sel_d   = rel_pick;
            valid_d = 1'b1;
            hold_d  = HOLD_ONE;
          end else begin
            grant_d = 8'h00;
            valid_d = 1'b0;
            hold_d  = '0;
          end
        end else if (!at_max) begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: begin
        grant_d = 8'h00;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  assign grant       = grant_q;
  assign sel         = sel_q;
  assign grant_valid = valid_q;
  assign hold_cnt    = hold_q;

endmodule
